epw22_cmd_arbiter: RTL

EPW22_CMD_ARBITER -- requirements
Module: epw22_cmd_arbiter

---
 rtl/epw22_cmd_arbiter_pkg.sv | 53 +++++
 rtl/epw22_rr_arb.sv | 30 +++
 rtl/epw22_cmd_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/epw22_cmd_arbiter_pkg.sv
// rtl/epw22_cmd_arbiter_pkg.sv - shared opcode, FSM state and op-class definitions
//
// Purpose: single home for the arbiter's opcode enum, op-class helpers,
//          default widths and FSM state encoding.
// Ports:   none (package).
package epw22_cmd_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 2;

  typedef enum logic [3:0] {
    OP_0 = 4'h0, OP_1 = 4'h1, OP_2 = 4'h2, OP_3 = 4'h3,
    OP_4 = 4'h4, OP_5 = 4'h5, OP_6 = 4'h6, OP_7 = 4'h7,
    OP_8 = 4'h8, OP_9 = 4'h9, OP_A = 4'hA, OP_B = 4'hB,
    OP_C = 4'hC, OP_D = 4'hD, OP_E = 4'hE, OP_F = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE_A = 2'd1,
    ST_ISSUE_B = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  function automatic logic op_is_two(input logic [3:0] op);
    case (op_e'(op))
      OP_3, OP_4, OP_8, OP_9, OP_A, OP_C, OP_D, OP_E: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_one(input logic [3:0] op);
    case (op_e'(op))
      OP_0, OP_1, OP_2, OP_B, OP_F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_result(input logic [3:0] op);
    case (op_e'(op))
      OP_8, OP_9, OP_A, OP_B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_reserved(input logic [3:0] op);
    case (op_e'(op))
      OP_5, OP_6, OP_7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/epw22_rr_arb.sv
// rtl/epw22_rr_arb.sv - two-requester round-robin grant with registered last-grant pointer
//
// Purpose: picks one of two requesters; on contention the one not granted
//          last wins. Pointer resets so requester 0 is favoured first.
// Ports:   clk, reset_n  - clock, async active-low reset
//          req[1:0]      - request vector
//          en            - grant is being taken this cycle (updates pointer)
//          gnt[1:0]      - one-hot combinational grant (zero when no request)
module epw22_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // last_q = 1 out of reset makes requester 0 the first contention winner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              last_q <= 1'b1;
    else if (en && (|req))     last_q <= gnt[1];
  end

endmodule

// File: rtl/epw22_cmd_arbiter.sv
// rtl/epw22_cmd_arbiter.sv - two-requester command arbiter driving a shared datapath
//
// Purpose: grants one requester at a time, issues its operands to the device
//          over one or two beats, waits for a result where the op produces
//          one, and returns exactly one response pulse to the owner.
// Ports:   clk, reset_n                     - clock, async active-low reset
//          req_valid/req_ready[1:0]         - command offer / one-cycle accept pulse
//          req_op/req_a/req_b/req_tag       - per-requester command fields
//          rsp_valid[1:0], rsp_err, rsp_result - completion pulse and status
//          dev_op/dev_data/dev_tag          - datapath command bus (zero when idle)
//          dev_ready/dev_valid/dev_result/dev_error - datapath status
//          stray                            - sticky: result seen with nothing outstanding
module epw22_cmd_arbiter
  import epw22_cmd_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][3:0]        req_op,
  input  logic [1:0][DATA_W-1:0] req_a,
  input  logic [1:0][DATA_W-1:0] req_b,
  input  logic [1:0][TAG_W-1:0]  req_tag,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_result,
  output logic [3:0]             dev_op,
  output logic [DATA_W-1:0]      dev_data,
  output logic [TAG_W-1:0]       dev_tag,
  input  logic                   dev_ready,
  input  logic                   dev_valid,
  input  logic [DATA_W-1:0]      dev_result,
  input  logic                   dev_error,
  output logic                   stray
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                owner_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gnt;
  logic                gidx;
  logic                grant_en, rsp_fire, err_d;
  logic [DATA_W-1:0]   result_d;
  logic [3:0]          dev_op_d;
  logic [DATA_W-1:0]   dev_data_d;
  logic [TAG_W-1:0]    dev_tag_d;

  epw22_rr_arb u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .en      (grant_en),
    .gnt     (gnt)
  );

  assign gidx = gnt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    rsp_fire   = 1'b0;
    err_d      = 1'b0;
    result_d   = '0;
    cnt_d      = '0;
    dev_op_d   = 4'h0;
    dev_data_d = '0;
    dev_tag_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_en = 1'b1;
          state_d  = ST_ISSUE_A;
        end
      end
      ST_ISSUE_A: begin
        // reserved ops park here for one cycle with the bus at NOP, then fail
        if (op_is_reserved(op_q)) begin
          rsp_fire = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (dev_ready) begin
          if (op_is_two(op_q))         state_d = ST_ISSUE_B;
          else if (op_is_result(op_q)) state_d = ST_WAIT;
          else begin
            rsp_fire = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_ISSUE_B: begin
        if (dev_error) begin
          rsp_fire = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (dev_ready) begin
          if (op_is_result(op_q)) state_d = ST_WAIT;
          else begin
            rsp_fire = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (dev_error) begin
          rsp_fire = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (dev_valid) begin
          rsp_fire = 1'b1;
          result_d = dev_result;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_fire = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    op_d  = grant_en ? req_op[gidx]  : op_q;
    a_d   = grant_en ? req_a[gidx]   : a_q;
    b_d   = grant_en ? req_b[gidx]   : b_q;
    tag_d = grant_en ? req_tag[gidx] : tag_q;

    // bus is registered from the next state so it lines up with the state it describes
    if ((state_d == ST_ISSUE_A || state_d == ST_ISSUE_B) && !op_is_reserved(op_d)) begin
      dev_op_d   = op_d;
      dev_tag_d  = tag_d;
      dev_data_d = (state_d == ST_ISSUE_A) ? a_d : b_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 4'h0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      req_ready  <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_err    <= 1'b0;
      rsp_result <= '0;
      dev_op     <= 4'h0;
      dev_data   <= '0;
      dev_tag    <= '0;
      stray      <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      if (grant_en) owner_q <= gidx;
      cnt_q      <= cnt_d;
      req_ready  <= grant_en ? gnt : 2'b00;
      rsp_valid  <= rsp_fire ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      rsp_err    <= rsp_fire & err_d;
      rsp_result <= rsp_fire ? result_d : '0;
      dev_op     <= dev_op_d;
      dev_data   <= dev_data_d;
      dev_tag    <= dev_tag_d;
      if (dev_valid && state_q != ST_WAIT) stray <= 1'b1;
    end
  end

endmodule
